// File: rtl/riscv_pkg.sv
// Shared types and constants for the RV32 pipeline.
// Fetch-side entries and defaults used by IF and IF/ID.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response channel.
// Fetch side is the master; memory is the slave.
interface fetch_unit_if #(
  parameter int XLEN = 32
) ();

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );

endinterface

// File: rtl/fetch_fifo.sv
// Generic synchronous FIFO with flush and count.
// Push and pop may coincide; a full FIFO accepts a push if it also pops.
module fetch_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic [31:0]
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  T                           data_i,
  input  logic                       pop_i,
  output T                           data_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  T              mem_q [DEPTH];
  logic [PW-1:0] rd_q, rd_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_pop  = pop_i & (cnt_q != '0);
  assign do_push = push_i & ((cnt_q != CW'(DEPTH)) | do_pop);

  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_pop)  rd_d = inc(rd_q);
      if (do_push) wr_d = inc(wr_q);
      cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_q];
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;

endmodule

// File: rtl/fetch_unit.sv
// IF stage: owns the PC, issues credit-limited fetches,
// drops wrong-path responses and presents {pc, instr} to decode.
module fetch_unit import riscv_pkg::*; #(
  parameter int              XLEN     = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = riscv_pkg::RESET_PC,
  parameter int              DEPTH    = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  fetch_unit_if.master    imem,
  input  logic            stall_if,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [31:0]     if_instr
);

  localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int CW1 = CW + 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } entry_t;

  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  trk_pc_q [DEPTH];
  logic [DEPTH-1:0] trk_live_q, trk_live_d;
  logic [PW-1:0]    trk_hd_q, trk_hd_d;
  logic [PW-1:0]    trk_tl_q, trk_tl_d;
  logic [CW-1:0]    trk_cnt_q, trk_cnt_d;

  logic [CW-1:0]    buf_cnt;
  logic [CW1-1:0]   used;
  logic             buf_empty;
  entry_t           buf_head, buf_in;
  logic             accept, rsp_pop, rsp_live;
  logic             buf_push, buf_pop;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Credits cover both requests in flight and buffered words,
  // so responses never need backpressure.
  assign used = CW1'(trk_cnt_q) + CW1'(buf_cnt);
  assign imem.imem_req_valid = (used < CW1'(DEPTH)) & ~redirect_valid;
  assign imem.imem_req_addr  = pc_q;

  assign accept   = imem.imem_req_valid & imem.imem_req_ready;
  assign rsp_pop  = imem.imem_rsp_valid & (trk_cnt_q != '0);
  assign rsp_live = trk_live_q[trk_hd_q] & ~redirect_valid;
  assign buf_push = rsp_pop & rsp_live;
  assign buf_pop  = ~buf_empty & ~stall_if;
  assign buf_in   = '{pc: trk_pc_q[trk_hd_q], instr: imem.imem_rsp_data};

  always_comb begin
    pc_d       = pc_q;
    trk_live_d = trk_live_q;
    trk_hd_d   = trk_hd_q;
    trk_tl_d   = trk_tl_q;
    if (rsp_pop) trk_hd_d = inc(trk_hd_q);
    if (accept) begin
      trk_live_d[trk_tl_q] = 1'b1;
      trk_tl_d             = inc(trk_tl_q);
      pc_d                 = pc_q + XLEN'(4);
    end
    trk_cnt_d = trk_cnt_q + CW'(accept) - CW'(rsp_pop);
    if (redirect_valid) begin
      pc_d       = {redirect_pc[XLEN-1:2], 2'b00};
      trk_live_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      trk_live_q <= '0;
      trk_hd_q   <= '0;
      trk_tl_q   <= '0;
      trk_cnt_q  <= '0;
    end else begin
      pc_q       <= pc_d;
      trk_live_q <= trk_live_d;
      trk_hd_q   <= trk_hd_d;
      trk_tl_q   <= trk_tl_d;
      trk_cnt_q  <= trk_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) trk_pc_q[trk_tl_q] <= pc_q;
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .T     (entry_t)
  ) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (redirect_valid),
    .push_i  (buf_push),
    .data_i  (buf_in),
    .pop_i   (buf_pop),
    .data_o  (buf_head),
    .empty_o (buf_empty),
    .count_o (buf_cnt)
  );

  assign if_valid = ~buf_empty;
  assign if_pc    = if_valid ? buf_head.pc : '0;
  assign if_instr = if_valid ? buf_head.instr : NOP_INSTR;

  // Pre-reset requests may still drain shortly after reset.
  logic [3:0] rst_age_q;

  always_ff @(posedge clk) begin
    if (!rst_n) rst_age_q <= '0;
    else if (rst_age_q != '1) rst_age_q <= rst_age_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst_n && rst_age_q == '1)
      assert (!(imem.imem_rsp_valid && trk_cnt_q == '0));
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed table, corner sequences,
// and random traffic against a queue-based reference model.
module tb_fetch_unit;

  localparam int DEPTH = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, stall_if, redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_pc, if_instr;

  fetch_unit_if #(.XLEN(32)) imem ();

  fetch_unit #(
    .XLEN     (32),
    .RESET_PC (32'h0),
    .DEPTH    (DEPTH)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem           (imem),
    .stall_if       (stall_if),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_instr       (if_instr)
  );

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  typedef struct { logic [31:0] pc; bit live; } trk_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
  typedef struct {
    bit rst; bit rdy; bit stl; bit en;
    bit rv; logic [31:0] addr; bit iv; logic [31:0] pc;
  } vec_t;

  mreq_t       mq [$];
  trk_t        m_trk [$];
  ent_t        m_buf [$];
  logic [31:0] m_pc;
  bit          armed;
  int          stale, lat_min, lat_max, last_due, cyc;
  logic [31:0] dxor;
  int          checks, errors;
  logic        s_rv, s_iv;
  logic [31:0] s_addr, s_pc, s_instr;
  vec_t        tv [16];
  bit          found;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic cycle(input bit rst, input bit rdy, input bit stl,
                       input bit rd, input logic [31:0] rpc);
    bit          rsp, acc, e_rv, e_iv, e_acc, popb;
    logic [31:0] rdata;
    int          d;
    trk_t        h;
    rsp   = 1'b0;
    rdata = 32'hBAD0_BAD0;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      rsp   = 1'b1;
      rdata = mq[0].addr ^ dxor;
    end
    rst_n          = ~rst;
    stall_if       = stl;
    redirect_valid = rd;
    redirect_pc    = rpc;
    imem.imem_req_ready = rdy && !rst && stale == 0;
    imem.imem_rsp_valid = rsp;
    imem.imem_rsp_data  = rdata;
    #1;
    s_rv    = imem.imem_req_valid;
    s_addr  = imem.imem_req_addr;
    s_iv    = if_valid;
    s_pc    = if_pc;
    s_instr = if_instr;
    e_rv = (m_trk.size() + m_buf.size() < DEPTH) && !rd;
    e_iv = m_buf.size() > 0;
    if (armed) begin
      chk("req_valid", 32'(s_rv), 32'(e_rv));
      chk("req_addr", s_addr, m_pc);
      chk("if_valid", 32'(s_iv), 32'(e_iv));
      chk("if_pc", s_pc, e_iv ? m_buf[0].pc : 32'h0);
      chk("if_instr", s_instr, e_iv ? m_buf[0].instr : NOP);
    end
    acc = s_rv && imem.imem_req_ready;
    if (rsp) begin
      mq.delete(0);
      if (stale > 0) stale--;
    end
    if (acc) begin
      d = cyc + $urandom_range(lat_max, lat_min);
      if (d <= last_due) d = last_due + 1;
      last_due = d;
      mq.push_back('{s_addr, d});
    end
    if (rst) stale = mq.size();
    e_acc = e_rv && imem.imem_req_ready;
    if (rst) begin
      m_pc = 32'h0;
      m_trk.delete();
      m_buf.delete();
      armed = 1'b1;
    end else if (armed) begin
      popb = e_iv && !stl;
      if (rd) begin
        if (rsp && m_trk.size() > 0) m_trk.delete(0);
        m_buf.delete();
        foreach (m_trk[i]) m_trk[i].live = 1'b0;
        m_pc = rpc & ~32'h3;
      end else begin
        if (popb) m_buf.delete(0);
        if (rsp && m_trk.size() > 0) begin
          h = m_trk.pop_front();
          if (h.live) m_buf.push_back('{h.pc, rdata});
        end
        if (e_acc) begin
          m_trk.push_back('{m_pc, 1'b1});
          m_pc = m_pc + 32'd4;
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    cycle(1, 0, 0, 0, 0);
    for (int g = 0; g < 50 && mq.size() > 0; g++) cycle(0, 0, 0, 0, 0);
    chk("reset_drain", mq.size(), 0);
  endtask

  initial begin
    rst_n = 1'b0; stall_if = 1'b0; redirect_valid = 1'b0;
    redirect_pc = '0;
    imem.imem_req_ready = 1'b0;
    imem.imem_rsp_valid = 1'b0;
    imem.imem_rsp_data  = '0;
    checks = 0; errors = 0; cyc = 0; stale = 0; last_due = 0;
    lat_min = 1; lat_max = 1; dxor = 32'h0; armed = 1'b0;

    // rst rdy stl en | rv addr iv pc ; memory returns address as data
    tv[0]  = '{1, 0, 0, 0, 0, 32'h00, 0, 32'h0};
    tv[1]  = '{0, 1, 0, 1, 1, 32'h00, 0, 32'h0};
    tv[2]  = '{0, 1, 0, 1, 1, 32'h04, 0, 32'h0};
    tv[3]  = '{0, 1, 0, 1, 1, 32'h08, 1, 32'h0};
    tv[4]  = '{0, 1, 0, 1, 1, 32'h0C, 1, 32'h4};
    tv[5]  = '{0, 1, 1, 1, 1, 32'h10, 1, 32'h8};
    tv[6]  = '{0, 1, 1, 1, 1, 32'h14, 1, 32'h8};
    for (int i = 7; i <= 10; i++)
      tv[i] = '{0, 1, 1, 1, 0, 32'h18, 1, 32'h8};
    tv[11] = '{0, 1, 0, 1, 0, 32'h18, 1, 32'h8};
    tv[12] = '{0, 1, 0, 1, 1, 32'h18, 1, 32'hC};
    tv[13] = '{0, 1, 0, 1, 1, 32'h1C, 1, 32'h10};
    tv[14] = '{0, 1, 0, 1, 1, 32'h20, 1, 32'h14};
    tv[15] = '{0, 1, 0, 1, 1, 32'h24, 1, 32'h18};

    @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) begin
      cycle(tv[i].rst, tv[i].rdy, tv[i].stl, 0, 0);
      if (tv[i].en) begin
        chk("tbl_rv", 32'(s_rv), 32'(tv[i].rv));
        chk("tbl_addr", s_addr, tv[i].addr);
        chk("tbl_iv", 32'(s_iv), 32'(tv[i].iv));
        chk("tbl_pc", s_pc, tv[i].pc);
        chk("tbl_instr", s_instr, tv[i].iv ? tv[i].pc : NOP);
      end
    end

    // Redirect with 0x10 and 0x14 in flight
    lat_min = 2; lat_max = 2;
    do_reset();
    found = 1'b0;
    for (int g = 0; g < 20 && !found; g++) begin
      cycle(0, 1, 0, 0, 0);
      if (s_rv && s_addr == 32'h14) found = 1'b1;
    end
    chk("rd_setup", 32'(found), 32'h1);
    cycle(0, 1, 0, 1, 32'h103);
    chk("rd_T_rv", 32'(s_rv), 32'h0);
    cycle(0, 1, 0, 0, 0);
    chk("rd_T1_rv", 32'(s_rv), 32'h1);
    chk("rd_T1_addr", s_addr, 32'h100);
    chk("rd_T1_iv", 32'(s_iv), 32'h0);
    found = 1'b0;
    for (int g = 0; g < 10 && !found; g++) begin
      cycle(0, 1, 0, 0, 0);
      if (s_iv) found = 1'b1;
    end
    chk("rd_resume", 32'(found), 32'h1);
    chk("rd_first_pc", s_pc, 32'h100);

    // Redirect under stall with 3 buffered entries
    lat_min = 1; lat_max = 1;
    do_reset();
    cycle(0, 1, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);
    cycle(0, 1, 1, 0, 0);
    cycle(0, 1, 1, 0, 0);
    cycle(0, 1, 1, 1, 32'h200);
    chk("rs_held_pc", s_pc, 32'h0);
    cycle(0, 1, 1, 0, 0);
    chk("rs_iv", 32'(s_iv), 32'h0);
    chk("rs_addr", s_addr, 32'h200);

    // Memory not ready for 3 cycles
    do_reset();
    for (int k = 0; k < 3; k++) begin
      cycle(0, 0, 0, 0, 0);
      chk("nr_rv", 32'(s_rv), 32'h1);
      chk("nr_addr", s_addr, 32'h0);
    end
    cycle(0, 1, 0, 0, 0);
    chk("nr_acc_addr", s_addr, 32'h0);
    cycle(0, 0, 0, 0, 0);
    chk("nr_next", s_addr, 32'h4);
    cycle(0, 0, 0, 0, 0);
    chk("nr_once", s_addr, 32'h4);

    // Reset with 3 requests in flight
    lat_min = 4; lat_max = 4;
    do_reset();
    cycle(0, 1, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);
    chk("mr_inflight", mq.size(), 3);
    cycle(1, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    chk("mr_iv", 32'(s_iv), 32'h0);
    chk("mr_pc", s_pc, 32'h0);
    chk("mr_instr", s_instr, NOP);
    chk("mr_addr", s_addr, 32'h0);
    for (int g = 0; g < 20 && mq.size() > 0; g++) begin
      cycle(0, 0, 0, 0, 0);
      chk("mr_late_iv", 32'(s_iv), 32'h0);
    end
    found = 1'b0;
    for (int g = 0; g < 20 && !found; g++) begin
      cycle(0, 1, 0, 0, 0);
      if (s_iv) found = 1'b1;
    end
    chk("mr_restart", 32'(found), 32'h1);
    chk("mr_first_pc", s_pc, 32'h0);
    chk("mr_first_in", s_instr, 32'h0);

    // Random traffic against the model
    lat_min = 1; lat_max = 3; dxor = 32'h1357_9BDF;
    for (int n = 0; n < 3000; n++) begin
      cycle($urandom_range(99) == 0,
            $urandom_range(3) != 0,
            $urandom_range(3) == 0,
            $urandom_range(19) == 0,
            ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                                     : ($urandom & 32'hFFF));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
